// File: rtl/key_cond_pkg.sv
// Shared types and sizing helpers for the pushbutton conditioner.
package key_cond_pkg;

   typedef enum logic [1:0] {
      RS_IDLE   = 2'd0,
      RS_DELAY  = 2'd1,
      RS_REPEAT = 2'd2
   } rep_state_t;

   // Bits needed to count 0..max(a,b)-1; never narrower than one bit.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: two-flop synchroniser, debounce filter and auto-repeat sequencer.
module key_channel
   import key_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_n_i,
   input  logic repeat_en_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic hold_o
);

   localparam int DW = cnt_width(DEBOUNCE_CYCLES, DEBOUNCE_CYCLES);
   localparam int TW = cnt_width(REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
   localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

   logic          s1_q;
   logic          s2_q;
   logic          level_q;
   logic [DW-1:0] db_cnt_q;
   logic [TW-1:0] timer_q;
   rep_state_t    state_q;
   logic          press_q;
   logic          release_q;
   logic          hold_q;
   logic          differ_s;
   logic          accept_s;

   // Raw key is active-low, so s2 equal to the active-high level means they disagree.
   always_comb begin
      differ_s = (s2_q == level_q);
      accept_s = differ_s && (db_cnt_q == DB_LAST);
   end

   // Two-flop synchroniser for the asynchronous raw key.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= key_n_i;
         s2_q <= s1_q;
      end
   end

   // Debounce counter and accepted level.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         db_cnt_q <= {DW{1'b0}};
         level_q  <= 1'b0;
      end else if (accept_s) begin
         db_cnt_q <= {DW{1'b0}};
         level_q  <= ~s2_q;
      end else if (differ_s) begin
         db_cnt_q <= db_cnt_q + {{(DW-1){1'b0}}, 1'b1};
      end else begin
         db_cnt_q <= {DW{1'b0}};
      end
   end

   // Repeat sequencer with registered strobes; an accepted release overrides any repeat tick.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= RS_IDLE;
         timer_q   <= {TW{1'b0}};
         press_q   <= 1'b0;
         release_q <= 1'b0;
         hold_q    <= 1'b0;
      end else begin
         press_q   <= 1'b0;
         release_q <= 1'b0;
         if (accept_s && !s2_q) begin
            press_q <= 1'b1;
            state_q <= RS_DELAY;
            timer_q <= {TW{1'b0}};
            hold_q  <= 1'b0;
         end else if (accept_s) begin
            release_q <= 1'b1;
            state_q   <= RS_IDLE;
            timer_q   <= {TW{1'b0}};
            hold_q    <= 1'b0;
         end else begin
            case (state_q)
               RS_IDLE: begin
                  timer_q <= {TW{1'b0}};
               end
               RS_DELAY: begin
                  if (!repeat_en_i) begin
                     timer_q <= {TW{1'b0}};
                  end else if (timer_q == DELAY_LAST) begin
                     press_q <= 1'b1;
                     state_q <= RS_REPEAT;
                     timer_q <= {TW{1'b0}};
                     hold_q  <= 1'b1;
                  end else begin
                     timer_q <= timer_q + {{(TW-1){1'b0}}, 1'b1};
                  end
               end
               RS_REPEAT: begin
                  if (!repeat_en_i) begin
                     state_q <= RS_DELAY;
                     timer_q <= {TW{1'b0}};
                     hold_q  <= 1'b0;
                  end else if (timer_q == PERIOD_LAST) begin
                     press_q <= 1'b1;
                     timer_q <= {TW{1'b0}};
                  end else begin
                     timer_q <= timer_q + {{(TW-1){1'b0}}, 1'b1};
                  end
               end
               default: begin
                  state_q <= RS_IDLE;
                  timer_q <= {TW{1'b0}};
                  hold_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign hold_o    = hold_q;

endmodule

// File: rtl/key_conditioner.sv
// N independent pushbutton channels feeding the Run/Continue control inputs.
module key_conditioner #(
   parameter int N_KEYS          = 2,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [N_KEYS-1:0] Key_n,
   input  logic [N_KEYS-1:0] Repeat_en,
   output logic [N_KEYS-1:0] Key_level,
   output logic [N_KEYS-1:0] Key_press,
   output logic [N_KEYS-1:0] Key_release,
   output logic [N_KEYS-1:0] Key_hold
);

   genvar g;
   generate
      for (g = 0; g < N_KEYS; g++) begin : g_ch
         key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
         ) u_ch (
            .clk_i      (Clk),
            .rst_ni     (Reset),
            .key_n_i    (Key_n[g]),
            .repeat_en_i(Repeat_en[g]),
            .level_o    (Key_level[g]),
            .press_o    (Key_press[g]),
            .release_o  (Key_release[g]),
            .hold_o     (Key_hold[g])
         );
      end
   endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench: a window/event-count reference model predicts every cycle's outputs.
module tb_key_conditioner;
   import key_cond_pkg::*;

   localparam int N  = 2;
   localparam int DB = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic         Clk       = 1'b0;
   logic         Reset     = 1'b0;
   logic [1:0]   Key_n     = 2'b11;
   logic [1:0]   Repeat_en = 2'b00;
   logic [1:0]   Key_level, Key_press, Key_release, Key_hold;

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [7:0]   exp_q[$];
   bit   [1:0]   hist[$];
   bit           lvl[N];
   bit           active[N];
   int           en_run[N];
   int           dur[N];

   key_conditioner #(
      .N_KEYS(N), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Key_n(Key_n), .Repeat_en(Repeat_en),
      .Key_level(Key_level), .Key_press(Key_press),
      .Key_release(Key_release), .Key_hold(Key_hold)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %b required %b", name, $time, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask

   // Reference: a change is accepted once the synchronised raw key has disagreed with the
   // accepted level for DB consecutive samples; repeat ticks fall at enabled-held counts RD, RD+RP, ...
   always @(posedge Clk) begin : model_b
      bit [1:0] pr, rl, hd, lv;
      bit       steady;
      pr = 2'b00; rl = 2'b00; hd = 2'b00; lv = 2'b00;
      if (!Reset) begin
         hist.delete();
         for (int i = 0; i < 8; i++) hist.push_back(2'b11);
         for (int c = 0; c < N; c++) begin
            lvl[c] = 1'b0; active[c] = 1'b0; en_run[c] = 0;
         end
      end else begin
         hist.push_back(Key_n);
         if (hist.size() > 16) void'(hist.pop_front());
         for (int c = 0; c < N; c++) begin
            steady = 1'b1;
            for (int j = 2; j <= DB + 1; j++)
               if (hist[hist.size() - 1 - j][c] != lvl[c]) steady = 1'b0;
            if (steady) begin
               lvl[c]    = ~lvl[c];
               en_run[c] = 0;
               active[c] = lvl[c];
               if (lvl[c]) pr[c] = 1'b1;
               else        rl[c] = 1'b1;
            end else if (active[c]) begin
               if (Repeat_en[c]) begin
                  en_run[c]++;
                  if (en_run[c] >= RD && ((en_run[c] - RD) % RP) == 0) pr[c] = 1'b1;
               end else begin
                  en_run[c] = 0;
               end
            end
            hd[c] = active[c] && (en_run[c] >= RD);
            lv[c] = lvl[c];
         end
      end
      exp_q.push_back({hd, rl, pr, lv});
   end

   // Monitor: compare the DUT outputs just after each edge against the predicted response.
   always @(posedge Clk) begin
      #1;
      if (exp_q.size() > 0)
         check("outputs{hold,rel,press,lvl}", {Key_hold, Key_release, Key_press, Key_level},
               exp_q.pop_front());
   end

   initial begin
      cyc(4);
      Reset = 1'b1;
      cyc(8);
      // Single press and release on key 0, auto-repeat disabled.
      Key_n[0] = 1'b0; cyc(12);
      Key_n[0] = 1'b1; cyc(10);
      // Three-cycle bounce must be rejected.
      Key_n[0] = 1'b0; cyc(3);
      Key_n[0] = 1'b1; cyc(10);
      // Long hold with repeat; release lands on a repeat tick while key 1 is pressed.
      Repeat_en[0] = 1'b1;
      Key_n[0] = 1'b0; cyc(34);
      Key_n = 2'b01; cyc(10);
      Key_n = 2'b11; cyc(10);
      // Drop repeat enable while repeating.
      Key_n[0] = 1'b0; cyc(20);
      Repeat_en[0] = 1'b0; cyc(10);
      Key_n[0] = 1'b1; cyc(10);
      // Asynchronous reset in the middle of repeating.
      Repeat_en = 2'b11;
      Key_n = 2'b00; cyc(20);
      #2 Reset = 1'b0;
      #1;
      check("async_reset_outputs", {Key_hold, Key_release, Key_press, Key_level}, 8'h00);
      check("async_reset_state0", {6'd0, dut.g_ch[0].u_ch.state_q}, {6'd0, RS_IDLE});
      check("async_reset_state1", {6'd0, dut.g_ch[1].u_ch.state_q}, {6'd0, RS_IDLE});
      cyc(3);
      Reset = 1'b1; cyc(6);
      Key_n = 2'b11; cyc(10);
      // Random holds and bounces with occasional repeat-enable changes.
      for (int c = 0; c < N; c++) dur[c] = 1;
      for (int t = 0; t < 800; t++) begin
         @(negedge Clk);
         for (int c = 0; c < N; c++) begin
            dur[c]--;
            if (dur[c] <= 0) begin
               Key_n[c] = ~Key_n[c];
               dur[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                                    : int'($urandom_range(6, 40));
            end
         end
         if ($urandom_range(0, 29) == 0) Repeat_en = 2'($urandom_range(0, 3));
      end
      Key_n = 2'b11; cyc(12);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
